// File: rtl/gpio_in_conditioner.sv
// Two-flop synchronizer plus per-bit stability-counter debounce for raw GPIO pins,
// with sticky write-1-to-clear rise/fall event flags.
module gpio_in_conditioner #(
  parameter int                 WIDTH           = 8,
  parameter int                 DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0]   RESET_LEVEL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] port_in,
  input  logic [WIDTH-1:0] event_clr,
  output logic [WIDTH-1:0] port_out,
  output logic [WIDTH-1:0] rise_flag,
  output logic [WIDTH-1:0] fall_flag,
  output logic             any_event
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] accept;

  // A bit is accepted once s2 has differed from port_out for DEBOUNCE_CYCLES
  // consecutive edges; any matching cycle drops the count back to zero.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != port_out[i]) begin
        if (cnt[i] == CNT_MAX) begin
          accept[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1        <= RESET_LEVEL;
      s2        <= RESET_LEVEL;
      port_out  <= RESET_LEVEL;
      rise_flag <= '0;
      fall_flag <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1        <= port_in;
      s2        <= s1;
      port_out  <= (port_out & ~accept) | (s2 & accept);
      // Setting takes priority over a simultaneous clear.
      rise_flag <= (rise_flag & ~event_clr) | (accept & s2);
      fall_flag <= (fall_flag & ~event_clr) | (accept & ~s2);
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

  assign any_event = |{rise_flag, fall_flag};

endmodule
